// File: rtl/serializer_pkg.sv
// Shared types and constants for the serializer egress datapath.
package serializer_pkg;

  localparam int unsigned DEFAULT_WORD_WIDTH = 32;
  localparam int unsigned PKT_CNT_W          = 16;

  // One buffered word plus its end-of-packet marker.
  typedef struct packed {
    logic                          last;
    logic [DEFAULT_WORD_WIDTH-1:0] word;
  } tx_entry_t;

  // Occupancy level at which upstream is told to throttle.
  function automatic int unsigned af_threshold(input int unsigned depth,
                                               input int unsigned margin);
    return depth - margin;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO holding {last, word} entries for the transmitter.
// Push is refused when full (even if a pop happens in the same cycle);
// pop is ignored when empty.
module tx_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  // Status is derived from registered occupancy only.
  always_comb begin
    full    = (count_q == CNT_W'(DEPTH));
    empty   = (count_q == '0);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    count   = count_q;
    head    = mem[rd_ptr_q];
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/transmitter.sv
// Egress end of the serializer: buffers pushed words and drives a
// ready/valid packet interface with regenerated sop framing.
module transmitter
  import serializer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_MARGIN  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    new_word_w,
  input  logic [WORD_WIDTH-1:0]   word_w,
  input  logic                    last_word_w,
  input  logic                    ready_in,
  output logic                    valid_out,
  output logic [WORD_WIDTH-1:0]   data_out,
  output logic                    sop_out,
  output logic                    eop_out,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    almost_full,
  output logic                    overflow_r,
  output logic [PKT_CNT_W-1:0]    pkts_sent
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = WORD_WIDTH + 1;
  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(af_threshold(DEPTH, AF_MARGIN));

  typedef struct packed {
    logic                  last;
    logic [WORD_WIDTH-1:0] word;
  } entry_t;

  entry_t                 push_entry;
  entry_t                 head_entry;
  logic [ENTRY_W-1:0]     head_bits;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full, fifo_empty;
  logic                   handshake;
  logic                   in_pkt_q;
  logic                   overflow_q;
  logic [PKT_CNT_W-1:0]   pkts_q;

  // Pack the incoming word with its end-of-packet flag.
  always_comb begin
    push_entry.last = last_word_w;
    push_entry.word = word_w;
  end

  tx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (new_word_w),
    .push_data (push_entry),
    .pop       (handshake),
    .head      (head_bits),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output side is a pure function of FIFO head and framing state; no ready_in -> valid path.
  always_comb begin
    head_entry  = entry_t'(head_bits);
    valid_out   = !fifo_empty;
    handshake   = valid_out && ready_in;
    data_out    = head_entry.word;
    sop_out     = valid_out && !in_pkt_q;
    eop_out     = valid_out && head_entry.last;
    count       = fifo_count;
    almost_full = (fifo_count >= AF_LEVEL);
    overflow_r  = overflow_q;
    pkts_sent   = pkts_q;
  end

  // Framing, drop-pulse and completed-packet counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt_q   <= 1'b0;
      overflow_q <= 1'b0;
      pkts_q     <= '0;
    end else begin
      overflow_q <= new_word_w && fifo_full;
      if (handshake) begin
        in_pkt_q <= !head_entry.last;
        if (head_entry.last) pkts_q <= pkts_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for transmitter with an ordered scoreboard of expected beats.
module tb_transmitter;
  import serializer_pkg::*;

  localparam int unsigned WW    = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          new_word_w;
  logic [WW-1:0] word_w;
  logic          last_word_w;
  logic          ready_in;
  logic          valid_out;
  logic [WW-1:0] data_out;
  logic          sop_out, eop_out;
  logic [3:0]    count;
  logic          almost_full, overflow_r;
  logic [15:0]   pkts_sent;

  int checks   = 0;
  int failures = 0;

  // Expected beats: {sop, eop, word}
  logic [WW+1:0] sb_q[$];
  logic          exp_sop_next = 1'b1;

  logic          prev_stall = 1'b0;
  logic [WW+1:0] held;

  transmitter #(
    .WORD_WIDTH (WW),
    .DEPTH      (DEPTH),
    .AF_MARGIN  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .new_word_w  (new_word_w),
    .word_w      (word_w),
    .last_word_w (last_word_w),
    .ready_in    (ready_in),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .sop_out     (sop_out),
    .eop_out     (eop_out),
    .count       (count),
    .almost_full (almost_full),
    .overflow_r  (overflow_r),
    .pkts_sent   (pkts_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one push for a cycle; accepted words enter the scoreboard.
  task automatic push(input logic [WW-1:0] w, input logic l, input logic accept);
    new_word_w  = 1'b1;
    word_w      = w;
    last_word_w = l;
    if (accept) begin
      sb_q.push_back({exp_sop_next, l, w});
      exp_sop_next = l;
    end
    @(posedge clk);
    #1;
    new_word_w  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || valid_out) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, {63'd0, (sb_q.size() == 0 && !valid_out)}, 64'd1);
  endtask

  // Monitor on the falling edge: score handshakes and check stall stability.
  always @(negedge clk) begin
    if (!rst && valid_out && prev_stall)
      check("stall_hold", {30'd0, sop_out, eop_out, data_out}, {30'd0, held});
    prev_stall = !rst && valid_out && !ready_in;
    held       = {sop_out, eop_out, data_out};
    if (!rst && valid_out && ready_in) begin
      if (sb_q.size() == 0) begin
        check("unexpected_beat", {30'd0, sop_out, eop_out, data_out}, 64'd0);
      end else begin
        check("beat", {30'd0, sop_out, eop_out, data_out}, {30'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b1; new_word_w = 1'b0; word_w = '0; last_word_w = 1'b0; ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", {63'd0, valid_out}, 64'd0);
    check("rst_sop", {63'd0, sop_out}, 64'd0);
    check("rst_eop", {63'd0, eop_out}, 64'd0);
    check("rst_count", {60'd0, count}, 64'd0);
    check("rst_af", {63'd0, almost_full}, 64'd0);
    check("rst_ovf", {63'd0, overflow_r}, 64'd0);
    check("rst_pkts", {48'd0, pkts_sent}, 64'd0);

    // Three-word packet with downstream always ready.
    ready_in = 1'b1;
    push(32'hA000_0000, 1'b0, 1'b1);
    check("lat_valid", {63'd0, valid_out}, 64'd1);
    check("lat_sop", {63'd0, sop_out}, 64'd1);
    push(32'hA000_0001, 1'b0, 1'b1);
    push(32'hA000_0002, 1'b1, 1'b1);
    wait_drain("drain_p3");
    check("pkts_p3", {48'd0, pkts_sent}, 64'd1);

    // Single-word packet, then a two-word packet that must start with sop.
    push(32'hB000_0000, 1'b1, 1'b1);
    check("single_sop_eop", {62'd0, sop_out, eop_out}, 64'd3);
    wait_drain("drain_single");
    check("pkts_single", {48'd0, pkts_sent}, 64'd2);
    push(32'hC000_0000, 1'b0, 1'b1);
    push(32'hC000_0001, 1'b1, 1'b1);
    wait_drain("drain_c");
    check("pkts_c", {48'd0, pkts_sent}, 64'd3);

    // Fill with downstream stalled, then overflow.
    ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push(32'hD000_0000 + i, (i == DEPTH - 1), 1'b1);
      check("fill_count", {60'd0, count}, 64'(i + 1));
      check("fill_af", {63'd0, almost_full}, {63'd0, (i + 1 >= 6)});
    end
    push(32'hDEAD_BEEF, 1'b1, 1'b0);
    check("ovf_pulse", {63'd0, overflow_r}, 64'd1);
    check("ovf_count", {60'd0, count}, 64'd8);
    @(posedge clk); #1;
    check("ovf_clear", {63'd0, overflow_r}, 64'd0);
    ready_in = 1'b1;
    wait_drain("drain_d");
    check("pkts_d", {48'd0, pkts_sent}, 64'd4);

    // Full FIFO with same-cycle pop and push: push still dropped.
    ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(32'hE000_0000 + i, (i == DEPTH - 1), 1'b1);
    ready_in = 1'b1;
    push(32'hE000_00FF, 1'b0, 1'b0);
    check("full_pop_ovf", {63'd0, overflow_r}, 64'd1);
    check("full_pop_count", {60'd0, count}, 64'd7);
    wait_drain("drain_e");
    check("pkts_e", {48'd0, pkts_sent}, 64'd5);

    // Random backpressure over a five-word packet.
    for (int i = 0; i < 5; i++) begin
      ready_in = 1'($urandom_range(0, 1));
      push(32'hF000_0000 + i, (i == 4), 1'b1);
    end
    for (int n = 0; n < 100 && (sb_q.size() != 0 || valid_out); n++) begin
      ready_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    ready_in = 1'b1;
    wait_drain("drain_rand");
    check("pkts_rand", {48'd0, pkts_sent}, 64'd6);

    // Reset after two of four words have gone out.
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h1000_0000 + i, (i == 3), 1'b1);
    ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ready_in = 1'b0;
    rst = 1'b1;
    sb_q.delete();
    exp_sop_next = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", {63'd0, valid_out}, 64'd0);
    check("mid_rst_count", {60'd0, count}, 64'd0);
    check("mid_rst_pkts", {48'd0, pkts_sent}, 64'd0);
    push(32'h2000_0000, 1'b1, 1'b1);
    check("post_rst_sop", {63'd0, sop_out}, 64'd1);
    ready_in = 1'b1;
    wait_drain("drain_post_rst");
    check("pkts_post_rst", {48'd0, pkts_sent}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
